// File: rtl/run_dump_ctrl.sv
// run_dump_ctrl: runs a group of SM cores until every core reports end of
// program, then dumps the first DUMP_WORDS data-memory words through a
// valid/ready stream.
// Optional feature: define RUN_DUMP_WATCHDOG_EN to stop a run after
// MAX_CYCLES RUN cycles. The run is flagged with timeout and still dumped.
// Memory read timing: mem_addr is a register that changes on the edge into RD.
// mem_rd_data is captured on the edge that leaves RD, one cycle after the
// address was launched.
module run_dump_ctrl #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DUMP_WORDS = 32,
    parameter int MAX_CYCLES = 10000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_CORES-1:0]  core_done,
    output logic                  core_reset,
    output logic                  mem_sel,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic [ADDR_WIDTH-1:0] dump_index,
    output logic                  busy,
    output logic                  finished,
    output logic [31:0]           run_cycles,
    output logic                  timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_RD,
        S_HOLD,
        S_DONE
    } state_e;

    // A zero-length dump skips the read states entirely.
    localparam bit DUMP_EN = (DUMP_WORDS != 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
        ADDR_WIDTH'((DUMP_WORDS == 0) ? 0 : DUMP_WORDS - 1);
    localparam state_e DUMP_ENTRY = DUMP_EN ? S_RD : S_DONE;

    state_e                state_q, state_d;
    logic [NUM_CORES-1:0]  done_q, done_d;
    logic [31:0]           run_cycles_q, run_cycles_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic                  dump_valid_q, dump_valid_d;
    logic [DATA_WIDTH-1:0] dump_data_q, dump_data_d;
    logic                  all_done;
    logic [31:0]           run_next;

`ifdef RUN_DUMP_WATCHDOG_EN
    localparam logic [31:0] MAX_RUN = 32'(MAX_CYCLES);
    logic timeout_q, timeout_d;
`endif

    // A core_done bit that arrives in this cycle already counts toward the all-done event.
    assign all_done = &(done_q | core_done);
    assign run_next = (run_cycles_q == '1) ? run_cycles_q : run_cycles_q + 32'd1;

    // Next-state and datapath update for the run/dump sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path that leaves one unassigned would infer a latch.
        state_d      = state_q;
        done_d       = done_q;
        run_cycles_d = run_cycles_q;
        index_d      = index_q;
        dump_valid_d = dump_valid_q;
        dump_data_d  = dump_data_q;
`ifdef RUN_DUMP_WATCHDOG_EN
        timeout_d    = timeout_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    done_d       = '0;
                    run_cycles_d = '0;
                    index_d      = '0;
`ifdef RUN_DUMP_WATCHDOG_EN
                    timeout_d    = 1'b0;
`endif
                end
            end
            S_RUN: begin
                run_cycles_d = run_next;
                done_d       = done_q | core_done;
                if (all_done) begin
                    state_d = DUMP_ENTRY;
                    index_d = '0;
                end
`ifdef RUN_DUMP_WATCHDOG_EN
                else if (run_next >= MAX_RUN) begin
                    state_d   = DUMP_ENTRY;
                    index_d   = '0;
                    timeout_d = 1'b1;
                end
`endif
            end
            S_RD: begin
                state_d      = S_HOLD;
                dump_data_d  = mem_rd_data;
                dump_valid_d = 1'b1;
            end
            S_HOLD: begin
                if (dump_valid_q && dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (index_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                        index_d = index_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            done_q       <= '0;
            run_cycles_q <= '0;
            index_q      <= '0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together from pre-edge values.
            state_q      <= state_d;
            done_q       <= done_d;
            run_cycles_q <= run_cycles_d;
            index_q      <= index_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
        end
    end

`ifdef RUN_DUMP_WATCHDOG_EN
    // Watchdog flag register, cleared by reset and by each new run.
    always_ff @(posedge clk) begin
        if (reset) timeout_q <= 1'b0;
        else       timeout_q <= timeout_d;
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // The block keeps the memory port for the whole dump (RD and HOLD).
    assign core_reset = (state_q != S_RUN);
    assign mem_sel    = (state_q == S_RD) || (state_q == S_HOLD);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign finished   = (state_q == S_DONE);
    assign mem_addr   = index_q;
    assign dump_index = index_q;
    assign dump_valid = dump_valid_q;
    assign dump_data  = dump_data_q;
    assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_run_dump_ctrl.sv
// tb_run_dump_ctrl: randomized self-checking bench for run_dump_ctrl.
// Each run is described by the RUN cycle at which each core reports done.
// The expected run length, timeout flag and dump word sequence are computed
// from that description and from a memory array. The bench builds the
// watchdog checks only when RUN_DUMP_WATCHDOG_EN is defined.
module tb_run_dump_ctrl;

    localparam int NC   = 4;
    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int NW   = 32;
    localparam int MAXC = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1, start = 1'b0, dump_ready = 1'b0;
    logic [NC-1:0] core_done = '0;
    logic          core_reset, mem_sel, dump_valid, busy, finished, timeout;
    logic [AW-1:0] mem_addr, dump_index;
    logic [DW-1:0] mem_rd_data, dump_data;
    logic [31:0]   run_cycles;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign mem_rd_data = mem[mem_addr];

    // Second instance with an empty dump.
    logic          start_z = 1'b0, dump_ready_z = 1'b1;
    logic [NC-1:0] core_done_z = '0;
    logic          core_reset_z, mem_sel_z, dump_valid_z, busy_z, finished_z, timeout_z;
    logic [AW-1:0] mem_addr_z, dump_index_z;
    logic [DW-1:0] mem_rd_data_z, dump_data_z;
    logic [31:0]   run_cycles_z;
    bit            mem_sel_z_seen = 1'b0;
    assign mem_rd_data_z = '0;

    run_dump_ctrl #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .DUMP_WORDS(NW), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset), .start(start), .core_done(core_done),
        .core_reset(core_reset), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_index(dump_index), .busy(busy),
        .finished(finished), .run_cycles(run_cycles), .timeout(timeout));

    run_dump_ctrl #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .DUMP_WORDS(0), .MAX_CYCLES(MAXC)) dut_z (
        .clk(clk), .reset(reset), .start(start_z), .core_done(core_done_z),
        .core_reset(core_reset_z), .mem_sel(mem_sel_z), .mem_addr(mem_addr_z),
        .mem_rd_data(mem_rd_data_z), .dump_valid(dump_valid_z), .dump_ready(dump_ready_z),
        .dump_data(dump_data_z), .dump_index(dump_index_z), .busy(busy_z),
        .finished(finished_z), .run_cycles(run_cycles_z), .timeout(timeout_z));

    // Remember whether the empty-dump instance ever claimed the memory port.
    always @(posedge clk) if (mem_sel_z) mem_sel_z_seen <= 1'b1;

    int n_checks = 0;
    int n_pass   = 0;
    int done_at [NC];   // RUN cycle at which each core reports done; 0 = never

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_core_reset"}, core_reset, 1);
        check({tag, "_mem_sel"},    mem_sel, 0);
        check({tag, "_valid"},      dump_valid, 0);
        check({tag, "_finished"},   finished, 0);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_timeout"},    timeout, 0);
        check({tag, "_data"},       dump_data, 0);
        check({tag, "_index"},      dump_index, 0);
        check({tag, "_addr"},       mem_addr, 0);
        check({tag, "_cycles"},     run_cycles, 0);
    endtask

    // One complete run followed by its dump. reset_at >= 0 asserts reset
    // (together with start and dump_ready) while that index is being offered.
    task automatic do_run(input bit sticky, input bit full_rate,
                          input int stall_idx, input int stall_len, input int reset_at);
        int l_exp, mx, exp_idx, used, stalled;
        bit never, to_exp, v, r;
        logic [DW-1:0] d;
        logic [AW-1:0] ix;
        mx = 0; never = 0; to_exp = 0;
        foreach (done_at[c]) begin
            if (done_at[c] == 0) never = 1;
            else if (done_at[c] > mx) mx = done_at[c];
        end
        l_exp = never ? (1 << 30) : mx;
`ifdef RUN_DUMP_WATCHDOG_EN
        if (l_exp > MAXC) begin
            l_exp  = MAXC;
            to_exp = 1;
        end
`endif
        start = 1; tick(); start = 0;
        check("run_entry_core_reset", core_reset, 0);
        check("run_entry_busy", busy, 1);
        check("run_entry_cycles", run_cycles, 0);
        for (int k = 1; k <= l_exp; k++) begin
            for (int c = 0; c < NC; c++)
                core_done[c] = sticky ? (done_at[c] != 0 && k >= done_at[c]) : (k == done_at[c]);
            start = 1'($urandom_range(0, 1));
            tick();
            if (k < l_exp) begin
                check("run_core_reset", core_reset, 0);
                check("run_mem_sel", mem_sel, 0);
                check("run_cycles", run_cycles, k);
            end
        end
        core_done = '0; start = 0;
        check("rd_cycles", run_cycles, l_exp);
        check("rd_timeout", timeout, to_exp);
        check("rd_mem_sel", mem_sel, 1);
        check("rd_core_reset", core_reset, 1);
        check("rd_addr", mem_addr, 0);
        check("rd_valid", dump_valid, 0);

        exp_idx = 0; used = 0; stalled = 0;
        while (exp_idx < NW && used < NW * 16 + 32) begin
            if (reset_at >= 0 && dump_valid && int'(dump_index) == reset_at) begin
                reset = 1; start = 1; dump_ready = 1;
                tick();
                reset = 0; start = 0; dump_ready = 0;
                check_idle("midreset");
                return;
            end
            if (full_rate) dump_ready = 1;
            else if (dump_valid && int'(dump_index) == stall_idx && stalled < stall_len) begin
                dump_ready = 0;
                stalled++;
            end else dump_ready = ($urandom_range(0, 3) != 0);
            start = full_rate ? 1'b0 : 1'($urandom_range(0, 1));
            v = dump_valid; r = dump_ready; d = dump_data; ix = dump_index;
            tick();
            used++;
            if (v && r) begin
                check("word_index", ix, exp_idx);
                check("word_data", d, mem[exp_idx]);
                check("valid_drop", dump_valid, 0);
                exp_idx++;
            end else if (v) begin
                check("stall_valid", dump_valid, 1);
                check("stall_data", dump_data, d);
                check("stall_index", dump_index, ix);
            end
        end
        dump_ready = 0; start = 0;
        check("dump_count", exp_idx, NW);
        if (full_rate) check("dump_cycles", used, 2 * NW);
        if (stall_len > 0) check("stall_seen", stalled, stall_len);
        check("done_finished", finished, 1);
        check("done_busy", busy, 0);
        check("done_core_reset", core_reset, 1);
        check("done_mem_sel", mem_sel, 0);
        check("done_cycles", run_cycles, l_exp);
        check("done_timeout", timeout, to_exp);
    endtask

    // Absolute time bound so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

    // Directed scenarios first, then randomized runs.
    initial begin
        tick(); tick();
        reset = 0;
        check_idle("reset");
        check("reset_z_finished", finished_z, 0);

        // All cores done at cycle 50, memory[i] = 3*i, consumer always ready.
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 3);
        foreach (done_at[c]) done_at[c] = 50;
        do_run(1, 1, -1, 0, -1);

        // Staggered single-cycle pulses, plus a 5-cycle stall at index 7.
        done_at[0] = 10; done_at[1] = 20; done_at[2] = 30; done_at[3] = 40;
        do_run(0, 0, 7, 5, -1);

        // Reset while index 12 is offered, then a fresh run from index 0.
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        foreach (done_at[c]) done_at[c] = $urandom_range(1, 30);
        do_run(1, 0, -1, 0, 12);
        foreach (done_at[c]) done_at[c] = $urandom_range(1, 30);
        do_run(1, 0, -1, 0, -1);

        // Randomized runs.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
            foreach (done_at[c]) done_at[c] = $urandom_range(1, 60);
            do_run(1'($urandom_range(0, 1)), 0, $urandom_range(0, NW - 1),
                   $urandom_range(0, 4), -1);
        end

`ifdef RUN_DUMP_WATCHDOG_EN
        // A hung run: no core ever finishes.
        foreach (done_at[c]) done_at[c] = 0;
        do_run(1, 0, -1, 0, -1);
        // All-done on the watchdog cycle itself leaves timeout clear.
        foreach (done_at[c]) done_at[c] = MAXC;
        do_run(1, 1, -1, 0, -1);
`endif

        // Empty dump: all-done leads straight to DONE.
        start_z = 1; tick(); start_z = 0;
        for (int k = 1; k <= 7; k++) begin
            core_done_z = (k == 7) ? '1 : '0;
            tick();
            if (k == 6) check("zero_busy_before", busy_z, 1);
        end
        core_done_z = '0;
        check("zero_finished", finished_z, 1);
        check("zero_cycles", run_cycles_z, 7);
        check("zero_valid", dump_valid_z, 0);
        check("zero_mem_sel_seen", mem_sel_z_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/run_dump_ctrl.md
RUN_DUMP_CTRL -- requirements
Module: run_dump_ctrl

Interface
REQ-001 Parameter NUM_CORES, default 4: number of SM cores in the run group.
REQ-002 Parameter ADDR_WIDTH, default 8: data-memory address width.
REQ-003 Parameter DATA_WIDTH, default 16: data-memory word width.
REQ-004 Parameter DUMP_WORDS, default 32: words dumped from address 0 upward, 0..2^ADDR_WIDTH.
REQ-005 Parameter MAX_CYCLES, default 10000: watchdog limit in RUN cycles.
REQ-006 clk  in  1  sole clock; all state changes on posedge clk.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to begin a run.
REQ-009 core_done  in  NUM_CORES  per-core end-of-program flag (CU in END state).
REQ-010 core_reset  out  1  holds all cores in reset while high.
REQ-011 mem_sel  out  1  1 = this block owns the data-memory port; 0 = cores own it.
REQ-012 mem_addr  out  ADDR_WIDTH  dump read address.
REQ-013 mem_rd_data  in  DATA_WIDTH  read data, valid one cycle after mem_addr is presented.
REQ-014 dump_valid  out  1  dump word available.
REQ-015 dump_ready  in  1  consumer accepts the word.
REQ-016 dump_data  out  DATA_WIDTH  dumped word.
REQ-017 dump_index  out  ADDR_WIDTH  address of dump_data.
REQ-018 busy  out  1  high in every state except IDLE and DONE.
REQ-019 finished  out  1  high in DONE.
REQ-020 run_cycles  out  32  number of RUN cycles of the last or current run, saturating at all-ones.
REQ-021 timeout  out  1  watchdog fired during the last run.

Function
REQ-022 States: IDLE, RUN, RD, HOLD, DONE.
REQ-023 IDLE: core_reset=1, mem_sel=0; start=1 -> RUN, clear run_cycles, the done latches and timeout.
REQ-024 RUN: core_reset=0, mem_sel=0, run_cycles increments each cycle.
- core_done bits are latched sticky per core.
- When all latches are set (including a bit arriving this cycle) -> RD at address 0.
REQ-025 DUMP_WORDS=0: the all-done event goes RUN -> DONE directly, with no dump.
REQ-026 RD: mem_sel=1, core_reset=1, mem_addr=index; the next cycle -> HOLD.
REQ-027 Entering HOLD: capture mem_rd_data into dump_data and set dump_valid=1.
- dump_data and dump_index stay stable while dump_valid=1 and dump_ready=0.
REQ-028 HOLD transfer occurs on a cycle with dump_valid=1 and dump_ready=1.
- If index = DUMP_WORDS-1 -> DONE.
- Otherwise index+1 -> RD.
- dump_valid deasserts the cycle after the transfer.
- Maximum throughput is one word per 2 cycles.
REQ-029 DONE: finished=1, core_reset=1, mem_sel=0; start=1 -> RUN (new run, counters cleared).
REQ-030 start in RUN, RD or HOLD is ignored.
REQ-031 dump_ready while dump_valid=0 is ignored.
REQ-032 Index arithmetic is ADDR_WIDTH wide; DUMP_WORDS=2^ADDR_WIDTH dumps every address with no wrap re-read.

Reset
REQ-033 reset=1 at a clock edge forces IDLE from any state, including mid-dump. It also sets:
- core_reset=1; mem_sel=0; dump_valid=0; finished=0; timeout=0.
- dump_data=0; dump_index=0; mem_addr=0; run_cycles=0.
- Done latches cleared.
REQ-034 reset takes priority over start and dump_ready in the same cycle.

Configuration
REQ-035 Macro RUN_DUMP_WATCHDOG_EN, when defined:
- In RUN, run_cycles reaching MAX_CYCLES sets timeout=1 and moves to RD, so a hung run is still dumped.
- A watchdog expiry and the all-done event in the same cycle leave timeout=0.
REQ-036 Macro RUN_DUMP_WATCHDOG_EN, when undefined: RUN waits indefinitely, timeout is constant 0, and MAX_CYCLES is unused.

Verification
REQ-037 Defaults; memory[i]=i*3; start; all core_done high at RUN cycle 50; dump_ready=1 -> run_cycles=50; 32 words 0,3,...,93 at indices 0..31; then finished=1.
REQ-038 core_done bits pulse one at a time at cycles 10, 20, 30, 40 -> RD entered only after cycle 40.
REQ-039 dump_ready held 0 for 5 cycles at index 7 -> dump_data=21 and dump_index=7 stable; no index 8 before acceptance.
REQ-040 reset asserted in HOLD at index 12 -> next cycle IDLE, dump_valid=0, core_reset=1; a later start runs from index 0.
REQ-041 RUN_DUMP_WATCHDOG_EN, MAX_CYCLES=100, core_done stuck 0 -> timeout=1 at run_cycles=100; full dump follows.
REQ-042 DUMP_WORDS=0 -> all-done gives DONE the next cycle; mem_sel never asserted.
